// File: rtl/ula_pkg.sv
// Shared ULA definitions: default widths and the scheduler state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ula_pkg;

  localparam int ULA_DATA_WIDTH_DEF = 8;
  localparam int ULA_SEL_WIDTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ula_sched_state_e;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/ula_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when no request is set.
module ula_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  // Walk the requesters starting at ptr and keep the first one found.
  always_comb begin : search
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ula_sched.sv
// Shares one ULA between NUM_REQ requesters, one operation in flight, id-tagged responses.
// Latency: accept T, ULA valid T+1, response T+2+L (timeout response T+2+TIMEOUT_CYCLES).
// Backpressure: req_ready one-hot only in IDLE; responses are single pulses with no stall.
module ula_sched
  import ula_pkg::*;
#(
  parameter  int DATA_WIDTH     = ULA_DATA_WIDTH_DEF,
  parameter  int SEL_WIDTH      = ULA_SEL_WIDTH_DEF,
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int ID_W           = $clog2(NUM_REQ),
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2_i,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel_i,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [2*DATA_WIDTH-1:0]       rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          ula_valid_o,
  output logic [DATA_WIDTH-1:0]         ula_data_1_o,
  output logic [DATA_WIDTH-1:0]         ula_data_2_o,
  output logic [SEL_WIDTH-1:0]          ula_sel_o,
  input  logic                          ula_valid_i,
  input  logic [2*DATA_WIDTH-1:0]       ula_data_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ula_sched_state_e       state, state_nxt;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_id;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        op_id;
  logic [DATA_WIDTH-1:0]  op_d1, op_d2;
  logic [SEL_WIDTH-1:0]   op_sel;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   cnt_done;

  ula_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid_i),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign cnt_done = (cnt == CNT_LAST);

  // Ready is masked while reset is asserted so every output reads zero during reset.
  assign req_ready_o = (state == IDLE && !rst) ? gnt : '0;

  // Operands are driven straight from the capture registers, so they hold between issues.
  assign ula_data_1_o = op_d1;
  assign ula_data_2_o = op_d2;
  assign ula_sel_o    = op_sel;

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and single-cycle strobes; a ULA result beats a coincident timeout.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ula_valid_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid_i) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ula_valid_o = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (ula_valid_i || cnt_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's operation and advance the round-robin pointer past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_d1  <= '0;
      op_d2  <= '0;
      op_sel <= '0;
      op_id  <= '0;
      ptr    <= '0;
    end else if (accept) begin
      op_d1  <= req_data_1_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      op_d2  <= req_data_2_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      op_sel <= req_sel_i[gnt_id*SEL_WIDTH +: SEL_WIDTH];
      op_id  <= gnt_id;
      ptr    <= ID_W'(rr_next(int'(gnt_id), NUM_REQ));
    end
  end

  // Timeout counter: cleared on issue, counts WAIT cycles without a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT && !ula_valid_i) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Response fields are loaded on leaving WAIT and held until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id_o   <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else if (state == WAIT) begin
      if (ula_valid_i) begin
        rsp_id_o   <= op_id;
        rsp_data_o <= ula_data_i;
        rsp_err_o  <= 1'b0;
      end else if (cnt_done) begin
        rsp_id_o   <= op_id;
        rsp_data_o <= '0;
        rsp_err_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ula_sched.sv
// Directed bench for ula_sched: reset, single op, fairness, pointer skip, timeout, boundary, reset in WAIT.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The ULA side is driven by hand at the cycles each scenario calls for.
module tb_ula_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_d1, req_d2;
  logic [7:0]  req_sel;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        u_valid_o;
  logic [7:0]  u_d1, u_d2;
  logic [1:0]  u_sel;
  logic        u_valid_i;
  logic [15:0] u_data_i;

  int n_assert = 0;
  int n_fail   = 0;

  ula_sched #(
    .DATA_WIDTH(8), .SEL_WIDTH(2), .NUM_REQ(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_1_i (req_d1),
    .req_data_2_i (req_d2),
    .req_sel_i    (req_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .ula_valid_o  (u_valid_o),
    .ula_data_1_o (u_d1),
    .ula_data_2_o (u_d2),
    .ula_sel_o    (u_sel),
    .ula_valid_i  (u_valid_i),
    .ula_data_i   (u_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One L=1 operation starting in the current cycle T; ends at T+4 just after the edge.
  task automatic do_op(input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                       input logic [7:0] exp_d1, input logic [7:0] exp_d2,
                       input logic [1:0] exp_sel, input logic [15:0] res);
    @(negedge clk);
    chk("grant", req_ready, exp_rdy);
    next_cyc();                                   // T+1
    @(negedge clk);
    chk("issue_valid", u_valid_o, 1);
    chk("issue_d1", u_d1, exp_d1);
    chk("issue_d2", u_d2, exp_d2);
    chk("issue_sel", u_sel, exp_sel);
    chk("ready_busy", req_ready, 0);
    next_cyc();                                   // T+2
    u_valid_i = 1'b1;
    u_data_i  = res;
    @(negedge clk);
    chk("rsp_early", rsp_valid, 0);
    next_cyc();                                   // T+3
    u_valid_i = 1'b0;
    u_data_i  = '0;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_data", rsp_data, res);
    chk("rsp_err", rsp_err, 0);
    next_cyc();                                   // T+4
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_d1    = 32'hAA12BBCC;
    req_d2    = 32'h55346677;
    req_sel   = 8'b11_01_10_00;
    u_valid_i = 1'b0;
    u_data_i  = '0;

    // Reset values, with requests pending to show ready is held low.
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_ula_valid", u_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ula_d1", u_d1, 0);
    next_cyc();
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("idle_no_req", req_ready, 0);

    // Single request from requester 2, L=1.
    next_cyc();
    req_valid = 4'b0100;
    do_op(4'b0100, 2'd2, 8'h12, 8'h34, 2'd1, 16'h0046);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("rsp_data_hold", rsp_data, 16'h0046);
    chk("ula_d1_hold", u_d1, 8'h12);

    // Fairness from a fresh reset with all four requesters valid.
    next_cyc();
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_d1    = 32'h33221100;
    req_d2    = 32'h83828180;
    req_sel   = 8'b11_10_01_00;
    @(negedge clk);
    chk("rst2_ready", req_ready, 0);
    next_cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] id;
      logic [3:0] oh;
      id = 2'(k % 4);
      oh = 4'b0001 << id;
      do_op(oh, id, {2'b00, id, 4'h0} | {6'd0, id} << 4 | {6'd0, id},
            8'h80 | {6'd0, id}, id, 16'hA000 + 16'(k));
    end

    // Pointer skip: after granting 1, only 0 and 3 valid -> 3 first, then 0.
    req_valid = 4'b1001;
    do_op(4'b1000, 2'd3, 8'h33, 8'h83, 2'd3, 16'hC0DE);
    do_op(4'b0001, 2'd0, 8'h00, 8'h80, 2'd0, 16'hC0DF);

    // Timeout: requester 1, ULA silent.
    req_valid = 4'b0010;
    @(negedge clk);
    chk("to_grant", req_ready, 4'b0010);
    next_cyc();                                   // T+1
    req_valid = 4'b0000;
    @(negedge clk);
    chk("to_issue", u_valid_o, 1);
    for (int c = 2; c <= 17; c++) begin
      next_cyc();
      @(negedge clk);
      chk("to_quiet", rsp_valid, 0);
    end
    next_cyc();                                   // T+18
    @(negedge clk);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_id", rsp_id, 1);
    next_cyc();                                   // T+19
    @(negedge clk);
    chk("to_pulse_end", rsp_valid, 0);
    chk("to_err_hold", rsp_err, 1);
    next_cyc();                                   // T+20: late result
    u_valid_i = 1'b1;
    u_data_i  = 16'hBEEF;
    @(negedge clk);
    chk("late_ignored", rsp_valid, 0);
    next_cyc();                                   // T+21
    u_valid_i = 1'b0;
    u_data_i  = '0;
    @(negedge clk);
    chk("late_no_rsp", rsp_valid, 0);
    chk("late_data_kept", rsp_data, 0);
    chk("late_no_issue", u_valid_o, 0);

    // Boundary: result arrives in the last WAIT cycle (T+17).
    next_cyc();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("bnd_grant", req_ready, 4'b0100);
    next_cyc();                                   // T+1
    req_valid = 4'b0000;
    for (int c = 2; c <= 16; c++) next_cyc();
    next_cyc();                                   // T+17
    u_valid_i = 1'b1;
    u_data_i  = 16'h1234;
    @(negedge clk);
    chk("bnd_quiet", rsp_valid, 0);
    next_cyc();                                   // T+18
    u_valid_i = 1'b0;
    u_data_i  = '0;
    @(negedge clk);
    chk("bnd_rsp_valid", rsp_valid, 1);
    chk("bnd_rsp_err", rsp_err, 0);
    chk("bnd_rsp_data", rsp_data, 16'h1234);
    chk("bnd_rsp_id", rsp_id, 2);

    // Reset while in WAIT; the late ULA result must produce nothing.
    next_cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rw_grant", req_ready, 4'b1000);
    next_cyc();                                   // T+1
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rw_issue", u_valid_o, 1);
    chk("rw_issue_d1", u_d1, 8'h33);
    next_cyc();                                   // T+2
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rw_ready", req_ready, 0);
    chk("rw_ula_valid", u_valid_o, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_rsp_data", rsp_data, 0);
    chk("rw_rsp_id", rsp_id, 0);
    chk("rw_rsp_err", rsp_err, 0);
    chk("rw_ula_d1", u_d1, 0);
    chk("rw_ula_sel", u_sel, 0);
    next_cyc();                                   // T+3
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rw_quiet3", rsp_valid, 0);
    next_cyc();                                   // T+4
    u_valid_i = 1'b1;
    u_data_i  = 16'h5555;
    @(negedge clk);
    chk("rw_quiet4", rsp_valid, 0);
    chk("rw_no_issue", u_valid_o, 0);
    next_cyc();                                   // T+5
    u_valid_i = 1'b0;
    u_data_i  = '0;
    @(negedge clk);
    chk("rw_quiet5", rsp_valid, 0);
    next_cyc();
    @(negedge clk);
    chk("rw_quiet6", rsp_valid, 0);

    // Pointer restarted at 0: with 1 and 3 valid, 1 wins.
    next_cyc();
    req_valid = 4'b1010;
    do_op(4'b0010, 2'd1, 8'h11, 8'h81, 2'd1, 16'h7777);
    req_valid = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_sched.md
# ula_sched

Round-robin scheduler that shares a single ULA instance between `NUM_REQ` requesters. It accepts one operation at a time from the requester side, drives the ULA `valid/data_1/data_2/sel` inputs, and waits for the ULA `valid_o`. It then returns the double-width result, tagged with the requester id, and flags a timeout if the ULA never answers. It sits between the requesting engines and the ULA; the ULA ports connect one-to-one to the ULA interface signals.

## Interface
Parameters:
- `DATA_WIDTH`, 8: ULA operand width; result is `2*DATA_WIDTH`.
- `SEL_WIDTH`, 2: ULA operation-select width.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `TIMEOUT_CYCLES`, 16: maximum cycles spent in WAIT before an error response, ≥2.

Ports:
- One clock; reset is asynchronous and active-high.
- `clk` input 1: the single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid_i` input `NUM_REQ`: per-requester operation request.
- `req_ready_o` output `NUM_REQ`: one-hot accept; the request is taken when `req_valid_i[i] & req_ready_o[i]`.
- `req_data_1_i` input `NUM_REQ*DATA_WIDTH`: packed operand 1; requester i occupies slice i.
- `req_data_2_i` input `NUM_REQ*DATA_WIDTH`: packed operand 2.
- `req_sel_i` input `NUM_REQ*SEL_WIDTH`: packed operation select.
- `rsp_valid_o` output 1: one-cycle response pulse.
- `rsp_id_o` output `$clog2(NUM_REQ)`: requester the response belongs to.
- `rsp_data_o` output `2*DATA_WIDTH`: ULA result.
- `rsp_err_o` output 1: response is a timeout.
- `ula_valid_o`, `ula_data_1_o`, `ula_data_2_o`, `ula_sel_o` output: go to the ULA `valid_i`, `data_i_1`, `data_i_2` and `sel_i` ports.
- `ula_valid_i` input 1 and `ula_data_i` input `2*DATA_WIDTH`: come from the ULA `valid_o` and `data_o` ports.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Winner = first requester with `req_valid_i` set, searching from pointer `ptr` upward modulo `NUM_REQ`.
  - `req_ready_o[winner]` is high combinationally in that same cycle.
  - Winner's operands, sel and id are registered; go to ISSUE.
  - `ptr` is set to `(winner+1) mod NUM_REQ`.
  - No valid request: stay in IDLE; `req_ready_o` = 0.
- **ISSUE**: `ula_valid_o`=1 for exactly one cycle with the registered operands and sel; clear the timeout counter; go to WAIT.
- **WAIT**
  - On `ula_valid_i`=1: capture `ula_data_i`; go to RESP with err=0.
  - Otherwise the counter increments. When the counter equals `TIMEOUT_CYCLES-1` without a valid, go to RESP with err=1 and data=0.
  - If both happen in the same cycle, the valid result wins (err=0).
- **RESP**: `rsp_valid_o`=1 for one cycle with `rsp_id_o`, `rsp_data_o` and `rsp_err_o`; return to IDLE. There is no response backpressure.
- `ula_valid_i` outside WAIT is ignored. This includes late results arriving after a timeout or after reset.
- `req_ready_o` is zero outside IDLE; at most one bit is ever set.
- `ula_data_1_o`, `ula_data_2_o` and `ula_sel_o` hold their last issued values outside ISSUE.
- `rsp_id_o`, `rsp_data_o` and `rsp_err_o` hold their values between pulses.

## Timing
- Request accepted in cycle T.
- `ula_valid_o` is high in cycle T+1.
- A ULA with latency L ≥ 1 returns its valid in cycle T+1+L.
- `rsp_valid_o` is high in cycle T+2+L; for L=1 this is T+3.
- Timeout response: `rsp_valid_o` in cycle T+2+`TIMEOUT_CYCLES`.
- Back-to-back throughput: at most one operation every L+3 cycles; the next acceptance is possible in the RESP+1 cycle.
- Reset values: all outputs 0; state IDLE; `ptr`=0; counter 0.
- Reset mid-operation: the in-flight operation is dropped with no response, and the state returns to IDLE immediately (asynchronously).
- A requester whose `req_valid_i` drops while it is not granted loses nothing; no request is latched outside IDLE.

## Structure
- Shared package `ula_pkg`:
  - `ula_sched_state_e` enum (IDLE, ISSUE, WAIT, RESP).
  - `ULA_DATA_WIDTH_DEF`/`ULA_SEL_WIDTH_DEF` constants (8 and 2), reused by the ULA interface and VIP.
- Sub-module `ula_rr_arbiter`: purely combinational; inputs `req`[`NUM_REQ`] and `ptr`; outputs one-hot `gnt` and `gnt_id`.
- The FSM, operand registers, timeout counter and pointer live in `ula_sched`.

## Test plan
- **Single request, L=1.** Requester 2 sends `data_1`=0x12, `data_2`=0x34, `sel`=1 at T. Required: `req_ready_o`=4'b0100 at T; ULA sees those values with valid at T+1. Model returns 0x0046 at T+2. Required: `rsp_valid_o`, `rsp_id_o`=2, `rsp_data_o`=0x0046, `rsp_err_o`=0 at T+3.
- **Fairness.** All four requesters held valid continuously from reset. Required: grant order 0,1,2,3,0,1; each grant arrives L+3 cycles after the previous one.
- **Pointer skip.** After a grant to 1, only requesters 0 and 3 are valid. Required: 3 is granted before 0.
- **Timeout.** `TIMEOUT_CYCLES`=16 and the ULA never responds. Required: `rsp_valid_o` with `rsp_err_o`=1, `rsp_data_o`=0 at T+18. A ULA valid injected at T+20 produces no response.
- **Boundary valid.** ULA valid arrives exactly in the last WAIT cycle (T+17). Required: normal response at T+18 with `rsp_err_o`=0.
- **Reset in WAIT.** Assert `rst` at T+2 for 1 cycle; the ULA then returns valid at T+4. Required: no `rsp_valid_o`; all outputs 0 during reset; the next request is serviced normally starting from `ptr`=0.
